// File: rtl/ie_defs.sv
//------------------------------------------------------------------------------
// Package : ie_defs
// Brief   : Shared definitions for the prog_loader byte-stream program loader:
//           command byte values and the frame-parser state encoding.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package ie_defs;

  // Command bytes that open a frame
  localparam logic [7:0] LDR_CMD_W = 8'h57;  // write block: AH AL LH LL data...
  localparam logic [7:0] LDR_CMD_R = 8'h52;  // run: PC_HI PC_LO
  localparam logic [7:0] LDR_CMD_H = 8'h48;  // halt: no payload

  // Frame parser states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    W_AH   = 3'd1,
    W_AL   = 3'd2,
    W_LH   = 3'd3,
    W_LL   = 3'd4,
    W_DATA = 3'd5,
    R_PH   = 3'd6,
    R_PL   = 3'd7
  } ldr_state_t;

endpackage : ie_defs

`default_nettype wire

// File: rtl/prog_loader.sv
//------------------------------------------------------------------------------
// Module  : prog_loader
// Brief   : Parses a framed host byte stream (W/R/H commands), writes payload
//           bytes into RAM while the CPU is held in reset, then loads the CPU
//           reset vector and releases the CPU.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module prog_loader
  import ie_defs::*;
#(
  parameter int unsigned MEM_SIZE   = 1024,
  parameter logic [15:0] PC_DEFAULT = 16'h0200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic        mem_write_en,
  output logic        cpu_run,
  output logic [15:0] pc_reset,
  output logic [7:0]  checksum,
  output logic        err_cmd,
  output logic        err_range,
  output logic        err_busy
);

  // Parser state and frame working registers
  ldr_state_t  state_q;
  logic [7:0]  hi_q;       // high byte of the 16-bit field currently being assembled
  logic [15:0] addr_q;     // next RAM address for W_DATA
  logic [15:0] cnt_q;      // data bytes still expected in the current W frame

  // Registered outputs
  logic [15:0] mem_addr_q;
  logic [7:0]  mem_data_q;
  logic        mem_write_en_q;
  logic        cpu_run_q;
  logic [15:0] pc_reset_q;
  logic [7:0]  checksum_q;
  logic        err_cmd_q;
  logic        err_range_q;
  logic        err_busy_q;

  // Combinational helpers
  logic        xfer_d;     // a byte is accepted this cycle
  logic [15:0] field_d;    // 16-bit field completed by the current byte
  logic        in_range_d; // current write address lies inside RAM

  // The loader can always accept a byte except while reset is asserted
  assign in_ready   = !rst;
  assign xfer_d     = in_valid && in_ready;
  assign field_d    = {hi_q, in_data};
  assign in_range_d = (32'(addr_q) < 32'(MEM_SIZE));

  // Frame parser: advances one step per accepted byte; all outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      hi_q           <= 8'h00;
      addr_q         <= 16'h0000;
      cnt_q          <= 16'h0000;
      mem_addr_q     <= 16'h0000;
      mem_data_q     <= 8'h00;
      mem_write_en_q <= 1'b0;
      cpu_run_q      <= 1'b0;
      pc_reset_q     <= PC_DEFAULT;
      checksum_q     <= 8'h00;
      err_cmd_q      <= 1'b0;
      err_range_q    <= 1'b0;
      err_busy_q     <= 1'b0;
    end else begin
      // The write strobe is a single-cycle pulse
      mem_write_en_q <= 1'b0;

      if (xfer_d) begin
        case (state_q)
          IDLE: begin
            case (in_data)
              LDR_CMD_W: begin
                state_q    <= W_AH;
                checksum_q <= 8'h00;
                // The frame is still parsed while the CPU owns the RAM port,
                // only its strobes are withheld.
                if (cpu_run_q) begin
                  err_busy_q <= 1'b1;
                end
              end
              LDR_CMD_R: begin
                state_q <= R_PH;
              end
              LDR_CMD_H: begin
                cpu_run_q <= 1'b0;
              end
              default: begin
                err_cmd_q <= 1'b1;
              end
            endcase
          end

          W_AH: begin
            hi_q    <= in_data;
            state_q <= W_AL;
          end

          W_AL: begin
            addr_q  <= field_d;
            state_q <= W_LH;
          end

          W_LH: begin
            hi_q    <= in_data;
            state_q <= W_LL;
          end

          W_LL: begin
            cnt_q <= field_d;
            // A zero-length block closes the frame without any writes
            if (field_d == 16'h0000) begin
              state_q <= IDLE;
            end else begin
              state_q <= W_DATA;
            end
          end

          W_DATA: begin
            mem_addr_q <= addr_q;
            mem_data_q <= in_data;
            addr_q     <= addr_q + 16'd1;
            checksum_q <= checksum_q + in_data;
            cnt_q      <= cnt_q - 16'd1;
            if (!cpu_run_q) begin
              if (in_range_d) begin
                mem_write_en_q <= 1'b1;
              end else begin
                err_range_q <= 1'b1;
              end
            end
            if (cnt_q == 16'd1) begin
              state_q <= IDLE;
            end
          end

          R_PH: begin
            hi_q    <= in_data;
            state_q <= R_PL;
          end

          R_PL: begin
            // Vector and run flag change in the same cycle so the CPU never
            // leaves reset with a stale vector.
            pc_reset_q <= field_d;
            cpu_run_q  <= 1'b1;
            state_q    <= IDLE;
          end

          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign mem_addr     = mem_addr_q;
  assign mem_data     = mem_data_q;
  assign mem_write_en = mem_write_en_q;
  assign cpu_run      = cpu_run_q;
  assign pc_reset     = pc_reset_q;
  assign checksum     = checksum_q;
  assign err_cmd      = err_cmd_q;
  assign err_range    = err_range_q;
  assign err_busy     = err_busy_q;

endmodule : prog_loader

`default_nettype wire

// File: tb/tb_prog_loader.sv
//------------------------------------------------------------------------------
// Module  : tb_prog_loader
// Brief   : Self-checking bench for prog_loader. Expected RAM writes are pushed
//           to a scoreboard queue when a frame is issued; a monitor pops and
//           compares every write strobe. Frame-level reference model.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_prog_loader;

  localparam int unsigned MEM_SIZE   = 1024;
  localparam logic [15:0] PC_DEFAULT = 16'h0200;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_write_en;
  logic        cpu_run;
  logic [15:0] pc_reset;
  logic [7:0]  checksum;
  logic        err_cmd;
  logic        err_range;
  logic        err_busy;

  prog_loader #(
    .MEM_SIZE  (MEM_SIZE),
    .PC_DEFAULT(PC_DEFAULT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .mem_write_en(mem_write_en),
    .cpu_run     (cpu_run),
    .pc_reset    (pc_reset),
    .checksum    (checksum),
    .err_cmd     (err_cmd),
    .err_range   (err_range),
    .err_busy    (err_busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t exp_q[$];
  int  strobe_cyc[$];

  // Reference model state (frame-level)
  logic        m_run;
  logic [15:0] m_pc;
  logic [7:0]  m_sum;
  logic        m_ecmd, m_erng, m_ebusy;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write
  always @(posedge clk) begin
    #1;
    if (mem_write_en === 1'b1) begin
      wr_t e;
      strobe_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: addr %h data %h, no write expected", mem_addr, mem_data);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", 32'(mem_addr), 32'(e.a));
        chk("write_data", 32'(mem_data), 32'(e.d));
      end
    end
  end

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "timeout");
  end

  task automatic model_reset();
    m_run = 1'b0; m_pc = PC_DEFAULT; m_sum = 8'h00;
    m_ecmd = 1'b0; m_erng = 1'b0; m_ebusy = 1'b0;
  endtask

  // Present one byte, optionally preceded by random idle cycles; returns #1 after the accepting edge
  task automatic send(input logic [7:0] b, input bit gaps);
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_cpu_run"},   32'(cpu_run),   32'(m_run));
    chk({tag, "_pc_reset"},  32'(pc_reset),  32'(m_pc));
    chk({tag, "_checksum"},  32'(checksum),  32'(m_sum));
    chk({tag, "_err_cmd"},   32'(err_cmd),   32'(m_ecmd));
    chk({tag, "_err_range"}, 32'(err_range), 32'(m_erng));
    chk({tag, "_err_busy"},  32'(err_busy),  32'(m_ebusy));
    chk({tag, "_pending"},   32'(exp_q.size()), 32'd0);
  endtask

  // W frame: model computes effects from the frame's rules, then the frame is sent
  task automatic do_w(input logic [15:0] a, input logic [7:0] d[$], input bit gaps, input string tag);
    logic [15:0] addr;
    int len = d.size();
    m_sum = 8'h00;
    if (m_run) m_ebusy = 1'b1;
    for (int i = 0; i < len; i++) begin
      addr  = a + 16'(i);
      m_sum = m_sum + d[i];
      if (!m_run) begin
        if (int'(addr) < int'(MEM_SIZE)) exp_q.push_back('{a: addr, d: d[i]});
        else m_erng = 1'b1;
      end
    end
    send(8'h57, gaps);
    send(a[15:8], gaps);
    send(a[7:0], gaps);
    send(8'(len >> 8), gaps);
    send(8'(len), gaps);
    for (int i = 0; i < len; i++) send(d[i], gaps);
    idle();
    check_state(tag);
  endtask

  task automatic do_r(input logic [15:0] pc, input bit gaps, input string tag);
    send(8'h52, gaps);
    send(pc[15:8], gaps);
    chk({tag, "_run_before"}, 32'(cpu_run),  32'(m_run));
    chk({tag, "_pc_before"},  32'(pc_reset), 32'(m_pc));
    send(pc[7:0], gaps);
    m_pc  = pc;
    m_run = 1'b1;
    chk({tag, "_pc_next"},  32'(pc_reset), 32'(pc));
    chk({tag, "_run_next"}, 32'(cpu_run),  32'd1);
    idle();
    check_state(tag);
  endtask

  task automatic do_h(input bit gaps, input string tag);
    send(8'h48, gaps);
    m_run = 1'b0;
    chk({tag, "_run_next"}, 32'(cpu_run), 32'd0);
    idle();
    check_state(tag);
  endtask

  task automatic do_bad(input logic [7:0] b, input bit gaps, input string tag);
    send(b, gaps);
    m_ecmd = 1'b1;
    idle();
    check_state(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    model_reset();
    exp_q.delete();
    chk({tag, "_mem_addr"}, 32'(mem_addr),     32'd0);
    chk({tag, "_mem_data"}, 32'(mem_data),     32'd0);
    chk({tag, "_mem_we"},   32'(mem_write_en), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
    check_state(tag);
  endtask

  initial begin
    logic [7:0]  d[$];
    logic [7:0]  sum_nogap;
    logic [15:0] ra;
    int          kind;

    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    do_reset("reset");

    // Basic write block: three back-to-back strobes
    strobe_cyc.delete();
    d = '{8'hA9, 8'h05, 8'h00};
    do_w(16'h0200, d, 1'b0, "w_basic");
    chk("w_basic_checksum_const", 32'(checksum), 32'hAE);
    chk("w_basic_strobes", 32'(strobe_cyc.size()), 32'd3);
    if (strobe_cyc.size() == 3) begin
      chk("w_basic_b2b_1", 32'(strobe_cyc[1] - strobe_cyc[0]), 32'd1);
      chk("w_basic_b2b_2", 32'(strobe_cyc[2] - strobe_cyc[1]), 32'd1);
    end

    // Run then halt
    do_r(16'h0200, 1'b0, "r_basic");
    do_h(1'b0, "h_basic");

    // Range boundary: 0x03FF written, 0x0400 suppressed
    strobe_cyc.delete();
    d = '{8'h11, 8'h22};
    do_w(16'h03FF, d, 1'b0, "w_range");
    chk("w_range_strobes", 32'(strobe_cyc.size()), 32'd1);
    chk("w_range_flag", 32'(err_range), 32'd1);

    // Write while CPU runs: no strobes, framing preserved
    do_r(16'h0400, 1'b0, "r_busy");
    strobe_cyc.delete();
    d = '{8'hFF};
    do_w(16'h0010, d, 1'b0, "w_busy");
    chk("w_busy_strobes", 32'(strobe_cyc.size()), 32'd0);
    chk("w_busy_flag", 32'(err_busy), 32'd1);
    do_r(16'h0300, 1'b0, "r_after_busy");
    do_h(1'b0, "h_after_busy");

    // Unknown command, then zero-length write
    do_bad(8'h00, 1'b0, "bad_cmd");
    strobe_cyc.delete();
    d.delete();
    do_w(16'h0123, d, 1'b0, "w_len0");
    chk("w_len0_strobes", 32'(strobe_cyc.size()), 32'd0);

    // Reset in the middle of a frame (after ADDR_LO)
    send(8'h57, 1'b0);
    send(8'h00, 1'b0);
    send(8'h10, 1'b0);
    do_reset("mid_rst");
    d = '{8'h01, 8'h02, 8'h03, 8'h04};
    do_w(16'h0100, d, 1'b0, "w_after_rst");

    // 16-byte block without and with input gaps
    d.delete();
    for (int i = 0; i < 16; i++) d.push_back(8'($urandom));
    do_w(16'h0080, d, 1'b0, "w16_nogap");
    sum_nogap = checksum;
    strobe_cyc.delete();
    do_w(16'h0080, d, 1'b1, "w16_gap");
    chk("w16_strobes", 32'(strobe_cyc.size()), 32'd16);
    chk("w16_sum_match", 32'(checksum), 32'(sum_nogap));

    // Address wrap past 0xFFFF: high addresses suppressed, 0 and 1 written
    d = '{8'h5A, 8'hA5, 8'h3C, 8'hC3};
    do_w(16'hFFFE, d, 1'b1, "w_wrap");

    // Randomised frame mix
    for (int n = 0; n < 24; n++) begin
      kind = int'($urandom_range(0, 5));
      case (kind)
        0, 1, 2: begin
          d.delete();
          for (int i = 0; i < int'($urandom_range(1, 20)); i++) d.push_back(8'($urandom));
          case ($urandom_range(0, 2))
            0:       ra = 16'($urandom_range(0, MEM_SIZE - 1));
            1:       ra = 16'($urandom_range(MEM_SIZE - 12, MEM_SIZE - 1));
            default: ra = 16'($urandom_range(16'hFFF0, 16'hFFFF));
          endcase
          do_w(ra, d, 1'($urandom_range(0, 1)), "rnd_w");
        end
        3: do_r(16'($urandom), 1'($urandom_range(0, 1)), "rnd_r");
        4: do_h(1'($urandom_range(0, 1)), "rnd_h");
        default: begin
          logic [7:0] b;
          b = 8'($urandom);
          if (b == 8'h57 || b == 8'h52 || b == 8'h48) b = 8'hEE;
          do_bad(b, 1'($urandom_range(0, 1)), "rnd_bad");
        end
      endcase
    end

    repeat (4) @(posedge clk);
    #2;
    chk("final_pending", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_prog_loader

`default_nettype wire
